// File: rtl/kvs_vs_regex_pkg.sv
// Shared types and helpers for the regex-engine dispatcher: FSM state encoding,
// default geometry, and the round-robin free-lane picker.
package kvs_vs_regex_pkg;

    localparam int DEF_NUM_ENGINES = 16;
    localparam int DEF_ENG_BITS    = 4;
    localparam int DEF_DATA_W      = 512;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        BCAST  = 2'd3
    } state_t;

    typedef struct packed {
        logic                    found;
        logic [DEF_ENG_BITS-1:0] idx;
    } rr_pick_t;

    // First non-busy lane at or above ptr, wrapping. The index add wraps for free
    // because the lane count is a power of two. The loop runs from the farthest
    // offset down so the nearest free lane is the one left in res.
    function automatic rr_pick_t rr_pick(input logic [DEF_NUM_ENGINES-1:0] busy,
                                         input logic [DEF_ENG_BITS-1:0]    ptr);
        rr_pick_t                res;
        logic [DEF_ENG_BITS-1:0] cand;
        res = '0;
        for (int i = DEF_NUM_ENGINES - 1; i >= 0; i--) begin
            cand = ptr + DEF_ENG_BITS'(i);
            if (!busy[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/kvs_vs_regex_if.sv
// Bundle of the value/config input streams, the per-lane engine buses and the
// in-order result stream. The scheduler takes the slave view.
interface kvs_vs_regex_if
    import kvs_vs_regex_pkg::*;
#(
    parameter int NUM_ENGINES = DEF_NUM_ENGINES,
    parameter int DATA_W      = DEF_DATA_W
);
    logic [DATA_W-1:0]             input_data;
    logic                          input_valid;
    logic                          input_last;
    logic                          input_ready;

    logic [DATA_W-1:0]             config_data;
    logic                          config_valid;
    logic                          config_ready;

    logic [NUM_ENGINES*DATA_W-1:0] eng_data;
    logic [NUM_ENGINES-1:0]        eng_valid;
    logic [NUM_ENGINES-1:0]        eng_last;
    logic [NUM_ENGINES-1:0]        eng_is_cfg;
    logic [NUM_ENGINES-1:0]        eng_ready;

    logic [NUM_ENGINES-1:0]        res_match;
    logic [NUM_ENGINES-1:0]        res_valid;
    logic [NUM_ENGINES-1:0]        res_ready;

    logic                          found_loc;
    logic                          found_valid;
    logic                          found_ready;

    modport slave (
        input  input_data, input_valid, input_last,
        output input_ready,
        input  config_data, config_valid,
        output config_ready,
        output eng_data, eng_valid, eng_last, eng_is_cfg,
        input  eng_ready,
        input  res_match, res_valid,
        output res_ready,
        output found_loc, found_valid,
        input  found_ready
    );

    modport master (
        output input_data, input_valid, input_last,
        input  input_ready,
        output config_data, config_valid,
        input  config_ready,
        input  eng_data, eng_valid, eng_last, eng_is_cfg,
        output eng_ready,
        output res_match, res_valid,
        input  res_ready,
        input  found_loc, found_valid,
        output found_ready
    );

endinterface

// File: rtl/kvs_vs_regex_order_fifo.sv
// Small synchronous FIFO holding the lane index of each dispatched value, so
// results can be returned in the order the values arrived.
module kvs_vs_regex_order_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Read/write pointer advance; the only state that needs reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/kvs_vs_regex_sched.sv
// Dispatcher in front of the regex engine lanes: streams each multi-beat value
// to a free lane chosen round-robin, broadcasts config only once every
// outstanding value has returned, and emits match bits in arrival order.
module kvs_vs_regex_sched
    import kvs_vs_regex_pkg::*;
#(
    parameter int NUM_ENGINES = DEF_NUM_ENGINES,
    parameter int ENG_BITS    = DEF_ENG_BITS,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    kvs_vs_regex_if.slave bus
);
    state_t                 state;
    logic [ENG_BITS-1:0]    sel;
    logic [ENG_BITS-1:0]    rr_ptr;
    logic [NUM_ENGINES-1:0] busy;
    logic [NUM_ENGINES-1:0] cfg_done;

    rr_pick_t               pick;
    logic [DATA_W-1:0]      word;
    logic [NUM_ENGINES-1:0] bc_vld;
    logic [NUM_ENGINES-1:0] bc_hs;
    logic                   bc_all;
    logic                   val_hs;
    logic                   first_hs;
    logic                   last_hs;
    logic [NUM_ENGINES-1:0] busy_set;
    logic [NUM_ENGINES-1:0] busy_clr;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [ENG_BITS-1:0]    head;
    logic                   found_vld;

    assign pick = rr_pick(busy, rr_ptr);

    // One shared word feeds every lane; eng_valid alone decides who takes it.
    assign word         = (state == BCAST) ? bus.config_data : bus.input_data;
    assign bus.eng_data = {NUM_ENGINES{word}};

    // Broadcast bookkeeping: config_ready fires only in the cycle the last
    // outstanding lane takes the word.
    assign bc_vld = {NUM_ENGINES{bus.config_valid}} & ~cfg_done;
    assign bc_hs  = bc_vld & bus.eng_ready;
    assign bc_all = (state == BCAST) && (&(cfg_done | bc_hs));

    // The selected lane was idle when picked, so its busy bit is still clear
    // exactly until the first beat of the value lands.
    assign val_hs   = (state == STREAM) && bus.input_valid && bus.eng_ready[sel];
    assign first_hs = val_hs && !busy[sel];
    assign last_hs  = val_hs && bus.input_last;

    // Results: only the lane at the head of the order FIFO may be popped.
    assign found_vld       = !fifo_empty && bus.res_valid[head];
    assign bus.found_valid = found_vld;
    assign bus.found_loc   = bus.res_match[head];
    assign bus.res_ready   = {{(NUM_ENGINES-1){1'b0}}, bus.found_ready & !fifo_empty} << head;

    assign fifo_push = first_hs;
    assign fifo_pop  = found_vld && bus.found_ready;

    // A lane being popped can never be the lane starting a new value, so set
    // and clear masks are disjoint.
    assign busy_set = {{(NUM_ENGINES-1){1'b0}}, first_hs} << sel;
    assign busy_clr = {{(NUM_ENGINES-1){1'b0}}, fifo_pop} << head;

    kvs_vs_regex_order_fifo #(
        .DEPTH (NUM_ENGINES),
        .W     (ENG_BITS)
    ) u_order_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (sel),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // One outstanding value per lane bounds the FIFO occupancy to its depth.
    assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

    // Handshake outputs follow the current state.
    always_comb begin
        bus.input_ready  = 1'b0;
        bus.config_ready = 1'b0;
        bus.eng_valid    = '0;
        bus.eng_last     = '0;
        bus.eng_is_cfg   = '0;
        case (state)
            STREAM: begin
                bus.input_ready    = bus.eng_ready[sel];
                bus.eng_valid[sel] = bus.input_valid;
                bus.eng_last[sel]  = bus.input_last;
            end
            BCAST: begin
                bus.eng_valid    = bc_vld;
                bus.eng_last     = '1;
                bus.eng_is_cfg   = '1;
                bus.config_ready = bc_all;
            end
            default: ;
        endcase
    end

    // Scheduler FSM plus lane occupancy and broadcast progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            rr_ptr   <= '0;
            busy     <= '0;
            cfg_done <= '0;
        end else begin
            busy <= (busy | busy_set) & ~busy_clr;
            case (state)
                IDLE: begin
                    if (bus.config_valid) begin
                        state <= DRAIN;
                    end else if (bus.input_valid && pick.found) begin
                        sel   <= pick.idx;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (last_hs) begin
                        rr_ptr <= sel + 1'b1;
                        state  <= IDLE;
                    end
                end
                DRAIN: begin
                    if (busy == '0) state <= BCAST;
                end
                BCAST: begin
                    if (bc_all) begin
                        cfg_done <= '0;
                        state    <= IDLE;
                    end else begin
                        cfg_done <= cfg_done | bc_hs;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
